midi_byte_parser: RTL and testbench
===================================

# midi_byte_parser

Converts the raw MIDI byte stream from the UART receiver into the per-byte stream consumed by the MIDI input multiplexer: byteready, cur_status, midibyte_nr and midi_in_data. It implements running status and channel-message length tracking, strips real-time bytes into a separate strobe, and flags an active-sensing timeout. It sits between the 31250-baud UART receiver and the UART side of the MIDI input multiplexer, on CLOCK_50.

## Interface
- CLK_HZ, 50_000_000, clock frequency used to derive the active-sensing timeout.
- AS_TIMEOUT_MS, 300, active-sensing silence limit in ms; TIMEOUT_CYC = CLK_HZ/1000*AS_TIMEOUT_MS, which is 15_000_000 at the defaults, held in a 24-bit counter.

Ports:
- reset_reg_N  in  1  asynchronous, active-low reset
- CLOCK_50  in  1  system clock
- rx_valid  in  1  one-cycle strobe, rx_data valid
- rx_data  in  8  received MIDI byte
- byteready  out  1  one-cycle strobe, outputs below valid
- cur_status  out  8  current (running) status byte, 8'h00 = none
- midibyte_nr  out  8  0 = status byte, 1..n = data byte index
- midi_in_data  out  8  byte being forwarded
- msg_done  out  1  one-cycle strobe with the last data byte of a channel message or with F7
- rt_valid  out  1  one-cycle strobe for a real-time byte (F8–FF)
- rt_data  out  8  real-time byte
- as_timeout  out  1  one-cycle strobe on active-sensing expiry

## Operation
- Reset value of every output, plus the internal counters and the need register, is 0.
- Byte classes are evaluated only when rx_valid=1:
  - **Channel status (80–EF):** cur_status<=byte, midibyte_nr<=0, midi_in_data<=byte, byteready=1. need<=1 for Cx/Dx and need<=2 otherwise.
  - **Data byte (bit7=0) with cur_status in 80–EF:**
    - If midibyte_nr==need, this is running status: midibyte_nr<=1.
    - Otherwise midibyte_nr<=midibyte_nr+1.
    - In both cases midi_in_data<=byte and byteready=1.
    - msg_done=1 when the new midibyte_nr equals need.
  - **F0 (SysEx start):** cur_status<=F0, midibyte_nr<=0, byteready=1.
    - Following data bytes are forwarded with midibyte_nr incrementing and saturating at 8'hFF.
  - **F7:** forwarded with byteready=1, midibyte_nr<=0, msg_done=1. cur_status<=00 on the following cycle.
  - **F1–F6:** not forwarded. cur_status<=00 and midibyte_nr<=0, which cancels running status.
  - **Data byte with cur_status==00:** dropped, no strobe.
  - **Real-time (F8–FF):** rt_valid=1 and rt_data<=byte. cur_status, midibyte_nr and need are untouched, so real-time bytes embedded inside a message do not break it.
- Active sensing:
  - Receipt of FE arms the timer.
  - Any rx_valid clears the counter.
  - If armed and the counter reaches TIMEOUT_CYC−1: as_timeout pulses once, the timer disarms and the counter clears.
  - FF (system reset byte) also disarms the timer and clears cur_status.

## Timing
- All outputs are registered with 1-cycle latency: rx_valid in cycle t gives its strobe in cycle t+1.
- byteready, msg_done, rt_valid and as_timeout are high for exactly one cycle and otherwise 0.
- Data outputs hold their value between strobes.
- rx_valid may assert on consecutive cycles; every byte is processed with no back-pressure.
- rx_valid coinciding with timer expiry: the byte wins. The counter clears and as_timeout does not pulse.
- Reset asserted mid-message returns all state to 0. A data byte received after reset is dropped.
- Counter width is 24 bits and must not wrap while armed.

## Test plan
- **Note-on with running status:** send 90,3C,64,3E,40.
  - Required byteready strobes: (90,nr0), (3C,nr1), (64,nr2,msg_done), (3E,nr1), (40,nr2,msg_done).
  - cur_status stays 90 throughout.
- **Two-byte message:** send C5,07,09.
  - Required: nr 0,1,1, with msg_done on both data bytes.
- **Real-time interleave:** send 90,F8,3C,FE,64.
  - Required: rt_valid for F8 and FE.
  - Channel bytes come out as nr0,1,2 unchanged, with msg_done on 64.
- **Cancel and drop:** send B0,07,F6,64.
  - Required: F6 produces no strobe and cur_status=00.
  - 64 is dropped with no byteready.
- **SysEx and timeout:** send F0 followed by 300 data bytes, then F7.
  - Required: midibyte_nr saturates at FF, F7 strobes with msg_done, and cur_status=00 one cycle later.
  - Then send FE and stay idle for 15_000_000 cycles: as_timeout pulses exactly once.
- **Reset mid-message:** send 90,3C, then pulse reset_reg_N low, then send 64.
  - Required: all outputs 0 after reset and no byteready for 64.

Source files
------------

// File: rtl/midi_byte_parser.sv
// rtl/midi_byte_parser.sv - MIDI byte stream parser with running status, real-time split and active-sensing timeout
module midi_byte_parser #(
    parameter int CLK_HZ        = 50_000_000,
    parameter int AS_TIMEOUT_MS = 300
) (
    input  logic       reset_reg_N,
    input  logic       CLOCK_50,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       byteready,
    output logic [7:0] cur_status,
    output logic [7:0] midibyte_nr,
    output logic [7:0] midi_in_data,
    output logic       msg_done,
    output logic       rt_valid,
    output logic [7:0] rt_data,
    output logic       as_timeout
);

    localparam int          TIMEOUT_CYC  = CLK_HZ / 1000 * AS_TIMEOUT_MS;
    // Terminal count; the counter stops here, so it never wraps while armed
    localparam logic [23:0] TIMEOUT_LAST = 24'(TIMEOUT_CYC - 1);

    typedef enum logic {
        AS_IDLE  = 1'b0,
        AS_ARMED = 1'b1
    } as_state_t;

    // Byte classes
    logic is_rt;
    logic is_chan_status;
    logic is_sysex_start;
    logic is_sysex_end;
    logic is_sys_common;

    assign is_rt          = (rx_data[7:3] == 5'b11111);
    assign is_chan_status = rx_data[7] && (rx_data[7:4] != 4'hF);
    assign is_sysex_start = (rx_data == 8'hF0);
    assign is_sysex_end   = (rx_data == 8'hF7);
    assign is_sys_common  = (rx_data[7:4] == 4'hF) && !is_rt && !is_sysex_start && !is_sysex_end;

    // Parser state
    logic [1:0] need;
    logic       clr_pending;

    // Status as seen by the byte arriving now: an F7 on the previous cycle already ended the SysEx
    logic [7:0] eff_status;
    logic       status_is_chan;
    logic       status_is_sysex;
    logic [7:0] need_ext;
    logic [7:0] nr_inc;
    logic [7:0] chan_nr_next;
    logic [7:0] sysex_nr_next;

    assign eff_status      = clr_pending ? 8'h00 : cur_status;
    assign status_is_chan  = eff_status[7] && (eff_status[7:4] != 4'hF);
    assign status_is_sysex = (eff_status == 8'hF0);
    assign need_ext        = {6'b0, need};
    assign nr_inc          = midibyte_nr + 8'd1;
    assign chan_nr_next    = (midibyte_nr == need_ext) ? 8'd1 : nr_inc;
    assign sysex_nr_next   = (midibyte_nr == 8'hFF) ? 8'hFF : nr_inc;

    // Next-state values for the parser registers
    logic [7:0] status_d;
    logic [7:0] nr_d;
    logic [7:0] data_d;
    logic [1:0] need_d;
    logic       byteready_d;
    logic       msg_done_d;
    logic       rt_valid_d;
    logic [7:0] rt_data_d;
    logic       clr_d;

    // Decode the incoming byte against the current running status
    always_comb begin
        status_d    = eff_status;
        nr_d        = midibyte_nr;
        data_d      = midi_in_data;
        need_d      = need;
        byteready_d = 1'b0;
        msg_done_d  = 1'b0;
        rt_valid_d  = 1'b0;
        rt_data_d   = rt_data;
        clr_d       = 1'b0;
        if (rx_valid) begin
            if (is_rt) begin
                rt_valid_d = 1'b1;
                rt_data_d  = rx_data;
                if (rx_data == 8'hFF) begin
                    status_d = 8'h00;
                end
            end else if (is_chan_status) begin
                status_d    = rx_data;
                nr_d        = 8'd0;
                data_d      = rx_data;
                byteready_d = 1'b1;
                need_d      = (rx_data[7:5] == 3'b110) ? 2'd1 : 2'd2;
            end else if (is_sysex_start) begin
                status_d    = rx_data;
                nr_d        = 8'd0;
                data_d      = rx_data;
                byteready_d = 1'b1;
            end else if (is_sysex_end) begin
                nr_d        = 8'd0;
                data_d      = rx_data;
                byteready_d = 1'b1;
                msg_done_d  = 1'b1;
                clr_d       = 1'b1;
            end else if (is_sys_common) begin
                status_d = 8'h00;
                nr_d     = 8'd0;
            end else if (status_is_chan) begin
                nr_d        = chan_nr_next;
                data_d      = rx_data;
                byteready_d = 1'b1;
                msg_done_d  = (chan_nr_next == need_ext);
            end else if (status_is_sysex) begin
                nr_d        = sysex_nr_next;
                data_d      = rx_data;
                byteready_d = 1'b1;
            end
        end
    end

    // Parser register bank
    always_ff @(posedge CLOCK_50 or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            cur_status   <= 8'h00;
            midibyte_nr  <= 8'h00;
            midi_in_data <= 8'h00;
            need         <= 2'd0;
            byteready    <= 1'b0;
            msg_done     <= 1'b0;
            rt_valid     <= 1'b0;
            rt_data      <= 8'h00;
            clr_pending  <= 1'b0;
        end else begin
            cur_status   <= status_d;
            midibyte_nr  <= nr_d;
            midi_in_data <= data_d;
            need         <= need_d;
            byteready    <= byteready_d;
            msg_done     <= msg_done_d;
            rt_valid     <= rt_valid_d;
            rt_data      <= rt_data_d;
            clr_pending  <= clr_d;
        end
    end

    // Active-sensing watchdog
    as_state_t   as_state;
    as_state_t   as_state_d;
    logic [23:0] as_cnt;
    logic [23:0] as_cnt_d;
    logic        as_timeout_d;

    // Watchdog next state: any byte restarts the count, FE arms, FF disarms
    always_comb begin
        as_state_d   = as_state;
        as_cnt_d     = as_cnt;
        as_timeout_d = 1'b0;
        if (rx_valid) begin
            as_cnt_d = 24'd0;
            if (rx_data == 8'hFE) begin
                as_state_d = AS_ARMED;
            end else if (rx_data == 8'hFF) begin
                as_state_d = AS_IDLE;
            end
        end else if (as_state == AS_ARMED) begin
            if (as_cnt == TIMEOUT_LAST) begin
                as_timeout_d = 1'b1;
                as_state_d   = AS_IDLE;
                as_cnt_d     = 24'd0;
            end else begin
                as_cnt_d = as_cnt + 24'd1;
            end
        end
    end

    // Watchdog state register
    always_ff @(posedge CLOCK_50 or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            as_state   <= AS_IDLE;
            as_cnt     <= 24'd0;
            as_timeout <= 1'b0;
        end else begin
            as_state   <= as_state_d;
            as_cnt     <= as_cnt_d;
            as_timeout <= as_timeout_d;
        end
    end

endmodule

// File: tb/tb_midi_byte_parser.sv
// tb/tb_midi_byte_parser.sv - self-checking bench for midi_byte_parser
module tb_midi_byte_parser;

    localparam int T_CYC = 50;

    logic       reset_reg_N;
    logic       CLOCK_50;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       byteready;
    logic [7:0] cur_status;
    logic [7:0] midibyte_nr;
    logic [7:0] midi_in_data;
    logic       msg_done;
    logic       rt_valid;
    logic [7:0] rt_data;
    logic       as_timeout;

    int checks;
    int failures;

    midi_byte_parser #(
        .CLK_HZ        (10_000),
        .AS_TIMEOUT_MS (5)
    ) dut (
        .reset_reg_N  (reset_reg_N),
        .CLOCK_50     (CLOCK_50),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .byteready    (byteready),
        .cur_status   (cur_status),
        .midibyte_nr  (midibyte_nr),
        .midi_in_data (midi_in_data),
        .msg_done     (msg_done),
        .rt_valid     (rt_valid),
        .rt_data      (rt_data),
        .as_timeout   (as_timeout)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        logic [7:0] b;
        logic       br;
        logic [7:0] st;
        logic [7:0] nr;
        logic [7:0] d;
        logic       md;
        logic       rt;
        logic [7:0] rtd;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [7:0] b, input logic br, input logic [7:0] st, input logic [7:0] nr,
                       input logic [7:0] d, input logic md, input logic rt, input logic [7:0] rtd);
        vec_t v;
        v.b = b; v.br = br; v.st = st; v.nr = nr; v.d = d; v.md = md; v.rt = rt; v.rtd = rtd;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge CLOCK_50);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic idle_tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic do_reset();
        reset_reg_N = 1'b0;
        #3;
        chk("reset_outputs",
            {byteready, msg_done, rt_valid, as_timeout, cur_status, midibyte_nr, midi_in_data, rt_data},
            64'd0);
        @(posedge CLOCK_50);
        #1;
        reset_reg_N = 1'b1;
        idle_tick();
    endtask

    // Waits up to limit cycles for as_timeout; returns cycle index or -1
    task automatic wait_timeout(input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            idle_tick();
            if (as_timeout && n < 0) n = i;
        end
    endtask

    initial begin
        int n;
        int extra;
        logic [7:0] exp_nr;
        checks      = 0;
        failures    = 0;
        rx_valid    = 1'b0;
        rx_data     = 8'h00;
        reset_reg_N = 1'b1;
        #2;
        do_reset();

        //   byte   br  st     nr     data   md  rt  rtd
        add(8'h90, 1, 8'h90, 8'd0, 8'h90, 0, 0, 8'h00);
        add(8'h3C, 1, 8'h90, 8'd1, 8'h3C, 0, 0, 8'h00);
        add(8'h64, 1, 8'h90, 8'd2, 8'h64, 1, 0, 8'h00);
        add(8'h3E, 1, 8'h90, 8'd1, 8'h3E, 0, 0, 8'h00);
        add(8'h40, 1, 8'h90, 8'd2, 8'h40, 1, 0, 8'h00);
        add(8'hC5, 1, 8'hC5, 8'd0, 8'hC5, 0, 0, 8'h00);
        add(8'h07, 1, 8'hC5, 8'd1, 8'h07, 1, 0, 8'h00);
        add(8'h09, 1, 8'hC5, 8'd1, 8'h09, 1, 0, 8'h00);
        add(8'h90, 1, 8'h90, 8'd0, 8'h90, 0, 0, 8'h00);
        add(8'hF8, 0, 8'h90, 8'd0, 8'h90, 0, 1, 8'hF8);
        add(8'h3C, 1, 8'h90, 8'd1, 8'h3C, 0, 0, 8'hF8);
        add(8'hFE, 0, 8'h90, 8'd1, 8'h3C, 0, 1, 8'hFE);
        add(8'h64, 1, 8'h90, 8'd2, 8'h64, 1, 0, 8'hFE);
        add(8'hB0, 1, 8'hB0, 8'd0, 8'hB0, 0, 0, 8'hFE);
        add(8'h07, 1, 8'hB0, 8'd1, 8'h07, 0, 0, 8'hFE);
        add(8'hF6, 0, 8'h00, 8'd0, 8'h07, 0, 0, 8'hFE);
        add(8'h64, 0, 8'h00, 8'd0, 8'h07, 0, 0, 8'hFE);
        add(8'hF0, 1, 8'hF0, 8'd0, 8'hF0, 0, 0, 8'hFE);
        add(8'h12, 1, 8'hF0, 8'd1, 8'h12, 0, 0, 8'hFE);
        add(8'hF7, 1, 8'hF0, 8'd0, 8'hF7, 1, 0, 8'hFE);
        add(8'h55, 0, 8'h00, 8'd0, 8'hF7, 0, 0, 8'hFE);
        add(8'hFF, 0, 8'h00, 8'd0, 8'hF7, 0, 1, 8'hFF);

        foreach (vecs[i]) begin
            send_byte(vecs[i].b);
            chk($sformatf("vec%0d_byte%02h", i, vecs[i].b),
                {byteready, msg_done, rt_valid, cur_status, midibyte_nr, midi_in_data, rt_data},
                {vecs[i].br, vecs[i].md, vecs[i].rt, vecs[i].st, vecs[i].nr, vecs[i].d, vecs[i].rtd});
        end
        idle_tick();
        chk("strobes_clear_after_vectors", {byteready, msg_done, rt_valid, as_timeout}, 64'd0);

        // SysEx with nr saturation, then F7 and delayed status clear
        do_reset();
        send_byte(8'hF0);
        chk("sysex_start", {byteready, cur_status, midibyte_nr}, {1'b1, 8'hF0, 8'h00});
        for (int i = 0; i < 300; i++) begin
            send_byte(8'(i % 128));
            exp_nr = (i + 1 > 255) ? 8'hFF : 8'(i + 1);
            chk($sformatf("sysex_data%0d", i), {byteready, msg_done, cur_status, midibyte_nr},
                {1'b1, 1'b0, 8'hF0, exp_nr});
        end
        send_byte(8'hF7);
        chk("sysex_end", {byteready, msg_done, cur_status, midibyte_nr, midi_in_data},
            {1'b1, 1'b1, 8'hF0, 8'h00, 8'hF7});
        idle_tick();
        chk("sysex_status_cleared", {byteready, msg_done, cur_status}, {1'b0, 1'b0, 8'h00});

        // Active-sensing timeout fires exactly once, T_CYC cycles after FE
        send_byte(8'hFE);
        wait_timeout(4 * T_CYC, n);
        chk("as_timeout_latency", 64'(n), 64'(T_CYC));
        extra = 0;
        for (int i = 0; i < 3 * T_CYC; i++) begin
            idle_tick();
            if (as_timeout) extra++;
        end
        chk("as_timeout_single_pulse", 64'(extra), 64'd0);

        // A byte arriving on the expiry cycle wins and restarts the count
        send_byte(8'hFE);
        for (int i = 0; i < T_CYC - 1; i++) idle_tick();
        send_byte(8'hF8);
        chk("as_byte_wins", {as_timeout, rt_valid}, {1'b0, 1'b1});
        wait_timeout(4 * T_CYC, n);
        chk("as_rearmed_latency", 64'(n), 64'(T_CYC));

        // FF disarms the watchdog
        send_byte(8'hFE);
        send_byte(8'hFF);
        wait_timeout(3 * T_CYC, n);
        chk("as_ff_disarms", 64'(n), 64'hFFFF_FFFF_FFFF_FFFF);

        // Reset mid-message: later data byte is dropped
        send_byte(8'h90);
        send_byte(8'h3C);
        chk("pre_reset_msg", {byteready, cur_status, midibyte_nr}, {1'b1, 8'h90, 8'h01});
        do_reset();
        send_byte(8'h64);
        chk("post_reset_drop", {byteready, msg_done, cur_status, midibyte_nr, midi_in_data},
            {1'b0, 1'b0, 8'h00, 8'h00, 8'h00});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
